// File: rtl/alu_mdu_seq.sv
// Execute-stage integer unit: base ALU ops take one registered cycle and
// M-extension ops run as an iterative shift-add / restoring-divide engine.
// The pipeline sends requests over a valid/ready handshake. Each operation
// returns one done pulse, and the result is held until the next done.
module alu_mdu_seq #(
  parameter int XLEN   = 32,
  parameter bit MDU_EN = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            alu_valid_i,
  output logic            alu_ready_o,
  input  logic [4:0]      alu_op_i,
  input  logic [XLEN-1:0] alu_data1_i,
  input  logic [XLEN-1:0] alu_data2_i,
  output logic [XLEN-1:0] alu_result_o,
  output logic            alu_done_o,
  output logic            alu_busy_o
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;           // {hi, lo}: product or {remainder, quotient}
  logic [XLEN-1:0]   opnd_q, opnd_d;         // multiplicand or divisor magnitude
  logic [2:0]        mop_q, mop_d;
  logic              neg_q, neg_d;           // final result needs negation
  logic              pend_q, pend_d;         // single-cycle result waiting to retire
  logic [XLEN-1:0]   pend_res_q, pend_res_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              done_q, done_d;

  logic              accept, is_m, is_div, div_signed, div_zero, div_ovf, special, iterative;
  logic              sign_a, sign_b, neg_a, neg_b;
  logic [XLEN-1:0]   mag_a, mag_b, base_res, quick_res, fix_res, quot, rem;
  logic [2*XLEN-1:0] prod, mul_next, div_next;
  logic [XLEN:0]     mul_sum, rem_sh, div_diff;
  logic [CW-1:0]     shamt;

  // FSM state register
  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the values that were present before the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state: only iterative M ops leave IDLE
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && iterative) state_d = S_BUSY;
      S_BUSY:  if (cnt_q == '0) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: accept only while idle
  always_comb begin
    alu_ready_o = (state_q == S_IDLE);
    alu_busy_o  = (state_q != S_IDLE);
  end

  // Request decode: special cases, operand signs and magnitudes
  always_comb begin
    accept     = alu_valid_i & alu_ready_o;
    is_m       = alu_op_i[4] & MDU_EN;
    is_div     = alu_op_i[2];
    div_signed = ~alu_op_i[0];
    div_zero   = (alu_data2_i == '0);
    div_ovf    = div_signed && (alu_data1_i == MIN_VAL) && (alu_data2_i == '1);
    special    = is_m && is_div && (div_zero || div_ovf);
    iterative  = is_m && !special;
    sign_a     = is_div ? div_signed : (alu_op_i[1:0] == 2'b01 || alu_op_i[1:0] == 2'b10);
    sign_b     = is_div ? div_signed : (alu_op_i[1:0] == 2'b01);
    neg_a      = sign_a & alu_data1_i[XLEN-1];
    neg_b      = sign_b & alu_data2_i[XLEN-1];
    mag_a      = neg_a ? -alu_data1_i : alu_data1_i;
    mag_b      = neg_b ? -alu_data2_i : alu_data2_i;
  end

  // Base ALU; unlisted encodings yield zero
  always_comb begin
    shamt    = alu_data2_i[CW-1:0];
    base_res = '0;
    case (alu_op_i[3:0])
      4'b0000: base_res = alu_data1_i + alu_data2_i;
      4'b1000: base_res = alu_data1_i - alu_data2_i;
      4'b0001: base_res = alu_data1_i << shamt;
      4'b0010: base_res = XLEN'($signed(alu_data1_i) < $signed(alu_data2_i));
      4'b0011: base_res = XLEN'(alu_data1_i < alu_data2_i);
      4'b0100: base_res = alu_data1_i ^ alu_data2_i;
      4'b0101: base_res = alu_data1_i >> shamt;
      4'b1101: base_res = $unsigned($signed(alu_data1_i) >>> shamt);
      4'b0110: base_res = alu_data1_i | alu_data2_i;
      4'b0111: base_res = alu_data1_i & alu_data2_i;
      4'b1001: base_res = XLEN'(alu_data1_i == alu_data2_i);
      4'b1010: base_res = XLEN'(alu_data1_i != alu_data2_i);
      4'b1100: base_res = XLEN'($signed(alu_data1_i) >= $signed(alu_data2_i));
      4'b1011: base_res = XLEN'(alu_data1_i >= alu_data2_i);
      default: base_res = '0;
    endcase
  end

  // Single-cycle result: base op, resolved division special case, or disabled M op
  always_comb begin
    quick_res = base_res;
    if (alu_op_i[4]) begin
      quick_res = '0;
      if (special) begin
        if (div_zero) quick_res = alu_op_i[1] ? alu_data1_i : '1;
        else          quick_res = alu_op_i[1] ? '0 : alu_data1_i;
      end
    end
  end

  // One iteration of shift-add multiply and of restoring divide
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    div_diff = rem_sh - {1'b0, opnd_q};
    div_next = div_diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  end

  // Sign correction and result select applied in FIX
  always_comb begin
    prod    = neg_q ? -acc_q : acc_q;
    quot    = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem     = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    fix_res = '0;
    if (mop_q[2])             fix_res = mop_q[1] ? rem : quot;
    else if (mop_q == 3'b000) fix_res = prod[XLEN-1:0];
    else                      fix_res = prod[2*XLEN-1:XLEN];
  end

  // Datapath next-state: operand capture, iteration, retirement
  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    mop_d      = mop_q;
    neg_d      = neg_q;
    pend_d     = accept & ~iterative;
    pend_res_d = (accept & ~iterative) ? quick_res : pend_res_q;
    done_d     = pend_q | (state_q == S_FIX);
    result_d   = result_q;
    if (pend_q)                 result_d = pend_res_q;
    else if (state_q == S_FIX)  result_d = fix_res;
    case (state_q)
      S_IDLE: begin
        if (accept && iterative) begin
          mop_d  = alu_op_i[2:0];
          neg_d  = (is_div && alu_op_i[1]) ? neg_a : (neg_a ^ neg_b);
          acc_d  = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
          opnd_d = is_div ? mag_b : mag_a;
          cnt_d  = CW'(XLEN - 1);
        end
      end
      S_BUSY: begin
        acc_d = mop_q[2] ? div_next : mul_next;
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
      end
      default: ;
    endcase
  end

  // Datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      mop_q      <= '0;
      neg_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_res_q <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      mop_q      <= mop_d;
      neg_q      <= neg_d;
      pend_q     <= pend_d;
      pend_res_q <= pend_res_d;
      result_q   <= result_d;
      done_q     <= done_d;
    end
  end

  assign alu_result_o = result_q;
  assign alu_done_o   = done_q;

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Bench for alu_mdu_seq: directed scenarios plus randomized operations checked
// against an arithmetic reference model. A second instance covers XLEN=64
// with the M unit disabled.
module tb_alu_mdu_seq;
  localparam logic [31:0] MIN32 = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, ready, done, busy;
  logic [4:0]  op;
  logic [31:0] d1, d2, result;
  logic        v64, ready64, done64, busy64;
  logic [4:0]  op64;
  logic [63:0] a64, b64, result64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_mdu_seq #(.XLEN(32), .MDU_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .alu_valid_i(valid), .alu_ready_o(ready),
    .alu_op_i(op), .alu_data1_i(d1), .alu_data2_i(d2),
    .alu_result_o(result), .alu_done_o(done), .alu_busy_o(busy)
  );

  alu_mdu_seq #(.XLEN(64), .MDU_EN(1'b0)) dut64 (
    .clk_i(clk), .rst_i(rst), .alu_valid_i(v64), .alu_ready_o(ready64),
    .alu_op_i(op64), .alu_data1_i(a64), .alu_data2_i(b64),
    .alu_result_o(result64), .alu_done_o(done64), .alu_busy_o(busy64)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: RV32 integer and M-extension semantics in plain arithmetic
  function automatic logic [31:0] model(input logic [4:0] mop, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = '0;
    p  = '0;
    if (!mop[4]) begin
      case (mop[3:0])
        4'b0000: r = a + b;
        4'b1000: r = a - b;
        4'b0001: r = a << b[4:0];
        4'b0010: r = {31'd0, sa < sb};
        4'b0011: r = {31'd0, a < b};
        4'b0100: r = a ^ b;
        4'b0101: r = a >> b[4:0];
        4'b1101: begin p = sa >>> b[4:0]; r = p[31:0]; end
        4'b0110: r = a | b;
        4'b0111: r = a & b;
        4'b1001: r = {31'd0, a == b};
        4'b1010: r = {31'd0, a != b};
        4'b1100: r = {31'd0, sa >= sb};
        4'b1011: r = {31'd0, a >= b};
        default: r = '0;
      endcase
    end else begin
      case (mop[2:0])
        3'b000: begin p = sa * sb; r = p[31:0]; end
        3'b001: begin p = sa * sb; r = p[63:32]; end
        3'b010: begin p = sa * longint'(ub); r = p[63:32]; end
        3'b011: begin p = ua * ub; r = p[63:32]; end
        3'b100: begin
          if (b == 0) r = '1;
          else if (a == MIN32 && b == '1) r = a;
          else begin p = sa / sb; r = p[31:0]; end
        end
        3'b101: begin
          if (b == 0) r = '1;
          else begin p = ua / ub; r = p[31:0]; end
        end
        3'b110: begin
          if (b == 0) r = a;
          else begin p = sa % sb; r = p[31:0]; end
        end
        default: begin
          if (b == 0) r = a;
          else begin p = ua % ub; r = p[31:0]; end
        end
      endcase
    end
    return r;
  endfunction

  // M ops other than division special cases take the multi-cycle path
  function automatic bit is_iter(input logic [4:0] mop, input logic [31:0] a, input logic [31:0] b);
    if (!mop[4]) return 1'b0;
    if (mop[2] && (b == 0 || (!mop[0] && a == MIN32 && b == '1))) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return MIN32;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op on an idle DUT, scramble inputs while busy, check result and timing
  task automatic run_op(input logic [4:0] mop, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag);
    int          exp_lat, lat;
    bit          hs_bad;
    logic [31:0] held;
    exp_lat = is_iter(mop, a, b) ? 33 : 1;
    hs_bad  = 1'b0;
    @(negedge clk);
    check({tag, "/ready_at_issue"}, ready, 1);
    valid = 1'b1; op = mop; d1 = a; d2 = b;
    @(posedge clk);
    lat = 0;
    while (1) begin
      @(negedge clk);
      if (done) break;
      if (exp_lat > 1) begin
        if (ready !== 1'b0 || busy !== 1'b1) hs_bad = 1'b1;
      end else if (busy !== 1'b0) hs_bad = 1'b1;
      if (busy === 1'b1) begin
        valid = 1'($urandom_range(0, 1));
        op = 5'($urandom); d1 = $urandom; d2 = $urandom;
      end else valid = 1'b0;
      @(posedge clk);
      lat++;
      if (lat > 100) break;
    end
    valid = 1'b0;
    check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "/result"}, result, exp);
    check({tag, "/handshake"}, hs_bad, 0);
    check({tag, "/ready_at_done"}, ready, 1);
    held = result;
    @(negedge clk);
    check({tag, "/single_done"}, done, 0);
    check({tag, "/result_held"}, result, held);
  endtask

  logic [4:0]  bb_op  [4] = '{5'b00000, 5'b01000, 5'b01101, 5'b00011};
  logic [31:0] bb_a   [4] = '{32'h7FFF_FFFF, 32'd0, 32'h8000_0000, 32'd1};
  logic [31:0] bb_b   [4] = '{32'd1, 32'd1, 32'd4, 32'd1};
  logic [31:0] bb_exp [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hF800_0000, 32'd0};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0]  rop;
    logic [31:0] ra, rb;
    bit          seen_done;

    rst = 1'b1; valid = 1'b0; op = '0; d1 = '0; d2 = '0;
    v64 = 1'b0; op64 = '0; a64 = '0; b64 = '0;
    repeat (2) @(negedge clk);
    check("reset/ready", ready, 1);
    check("reset/done", done, 0);
    check("reset/busy", busy, 0);
    check("reset/result", result, 0);
    rst = 1'b0;

    // Back-to-back base ops, one accepted per cycle
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i >= 2 && i < 6) begin
        check($sformatf("b2b%0d/done", i - 2), done, 1);
        check($sformatf("b2b%0d/result", i - 2), result, bb_exp[i-2]);
      end else if (i == 1 || i == 6) check($sformatf("b2b/no_done_%0d", i), done, 0);
      if (i < 4) begin
        check($sformatf("b2b%0d/ready", i), ready, 1);
        valid = 1'b1; op = bb_op[i]; d1 = bb_a[i]; d2 = bb_b[i];
      end else valid = 1'b0;
    end

    // Directed multiply/divide and special cases
    run_op(5'b10001, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, "mulh");
    run_op(5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");
    run_op(5'b10100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div");
    run_op(5'b10110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem");
    run_op(5'b10101, 32'd100, 32'd7, 32'd14, "divu");
    run_op(5'b10111, 32'd100, 32'd7, 32'd2, "remu");
    run_op(5'b10100, 32'd5, 32'd0, 32'hFFFF_FFFF, "div_by_zero");
    run_op(5'b10110, 32'd5, 32'd0, 32'd5, "rem_by_zero");
    run_op(5'b10100, MIN32, 32'hFFFF_FFFF, MIN32, "div_overflow");
    run_op(5'b10110, MIN32, 32'hFFFF_FFFF, 32'd0, "rem_overflow");

    // Abort a divide with reset after ten busy cycles
    @(negedge clk);
    valid = 1'b1; op = 5'b10100; d1 = 32'd1000; d2 = 32'd3;
    @(posedge clk);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      valid = 1'($urandom_range(0, 1));
      op = 5'($urandom); d1 = $urandom; d2 = $urandom;
    end
    @(negedge clk);
    valid = 1'b0;
    check("abort/busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check("abort/ready", ready, 1);
    check("abort/done", done, 0);
    check("abort/busy", busy, 0);
    check("abort/result", result, 0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    check("abort/no_done", seen_done, 0);
    run_op(5'b00000, 32'd2, 32'd2, 32'd4, "add_after_abort");

    // Randomized operations against the model
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) rop = {1'b0, 4'($urandom)};
      else                           rop = {2'b10, 3'($urandom)};
      ra = pick_val();
      rb = pick_val();
      run_op(rop, ra, rb, model(rop, ra, rb), $sformatf("rand%0d_op%b", n, rop));
    end

    // XLEN=64 with the M unit disabled
    @(negedge clk);
    v64 = 1'b1; op64 = 5'b00001; a64 = 64'd1; b64 = 64'd63;
    @(posedge clk);
    @(negedge clk);
    v64 = 1'b0;
    check("x64_sll/early_done", done64, 0);
    @(negedge clk);
    check("x64_sll/done", done64, 1);
    check("x64_sll/result", result64, 64'h8000_0000_0000_0000);
    @(negedge clk);
    v64 = 1'b1; op64 = 5'b10000; a64 = 64'd3; b64 = 64'd4;
    @(posedge clk);
    @(negedge clk);
    v64 = 1'b0;
    check("x64_mul/busy", busy64, 0);
    check("x64_mul/early_done", done64, 0);
    @(negedge clk);
    check("x64_mul/done", done64, 1);
    check("x64_mul/result", result64, 64'd0);
    check("x64_mul/ready", ready64, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_mdu_seq.md
# alu_mdu_seq

Parametrised, handshaked successor to the single-cycle integer ALU. It adds the full RV32M/RV64M multiply/divide/remainder set as an iterative multi-cycle unit and keeps base ALU ops at one registered cycle. It sits in the execute stage. The pipeline issues one operation through a valid/ready handshake and receives a one-cycle done pulse with a held result.

## Interface
Parameters:
- XLEN, 32: datapath width; legal values 32, 64.
- MDU_EN, 1: 1 enables the M-extension iterative unit; 0 makes M ops complete in 1 cycle with result 0.

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- alu_valid_i  in  1  operation request.
- alu_ready_o  out  1  block can accept; accept = valid & ready at a rising edge.
- alu_op_i  in  5  [4]=0: base op, [3:0] encoded as: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111, EQ 1001, NEQ 1010, GE 1100, GEU 1011. [4]=1: M op, [2:0] = MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111.
- alu_data1_i  in  XLEN  operand A (rs1).
- alu_data2_i  in  XLEN  operand B (rs2/imm).
- alu_result_o  out  XLEN  registered result, held until next done.
- alu_done_o  out  1  one-cycle pulse, result valid.
- alu_busy_o  out  1  iterative operation in flight.

## Operation
- Operands and op are captured on accept; input changes afterwards are ignored.
- Base ops use two's-complement arithmetic modulo 2^XLEN.
  - Shift amount = data2[$clog2(XLEN)-1:0].
  - SRA sign-fills.
  - Compare ops return zero-extended 0/1.
  - Unlisted base encodings return 0.
- FSM states: IDLE, BUSY, FIX.
  - IDLE: ready=1. A base op or special-case M op is accepted and completes in place; the state stays IDLE.
  - An iterative M op moves IDLE->BUSY. The counter is loaded with XLEN-1, and magnitudes are taken for signed forms.
  - BUSY: one iteration per cycle.
    - Multiply: shift-add into a 2*XLEN accumulator.
    - Divide: restoring, one quotient bit per cycle.
    - The counter decrements each cycle. On the iteration with counter==0 the state moves to FIX.
  - FIX: applies sign correction, loads alu_result_o, pulses done, then returns to IDLE.
- MUL returns the low XLEN bits. MULH, MULHSU and MULHU return the high XLEN bits with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
- Signed division truncates toward zero. The remainder takes the sign of the dividend.
- Special cases are resolved in 1 cycle without entering BUSY:
  - Divide by zero: DIV/DIVU = all ones; REM/REMU = data1.
  - Signed overflow (data1 = -2^(XLEN-1), data2 = -1): DIV = data1; REM = 0.
- With MDU_EN=0, every M op behaves like a base op with result 0.

## Timing
- Reset values: alu_ready_o=1, alu_done_o=0, alu_busy_o=0, alu_result_o=0, state=IDLE, counter=0.
- Latency is counted in rising edges after the accepting edge:
  - Base and special-case M ops: done at +1.
  - Iterative M ops: done at +XLEN+1 (XLEN BUSY edges + FIX).
- alu_ready_o=0 and alu_busy_o=1 from the edge after accept through FIX. alu_ready_o returns to 1 in the cycle done is high.
- A new request is accepted in the same cycle done is high. Back-to-back base ops complete one per cycle.
- alu_valid_i while ready=0 is ignored. The requester must hold the request; nothing is queued.
- alu_done_o is never high for two consecutive cycles from one operation. Back-to-back base ops give a continuous done stream, one pulse per op.
- rst_i asserted mid-operation aborts immediately. All outputs return to their reset values and no done is produced for the aborted op.
- alu_result_o changes only on a done edge or on reset.

## Test plan
- Reset, then ADD 0x7FFFFFFF+1, SUB 0-1, SRA 0x80000000>>4, SLTU 1<1 back-to-back every cycle -> results 0x80000000, 0xFFFFFFFF, 0xF8000000, 0, each done exactly one edge after its accept.
- MULH -2×3, then MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF and 0xFFFFFFFE, done 33 edges after accept, ready low throughout.
- DIV -7/2, then REM -7/2 -> 0xFFFFFFFD and 0xFFFFFFFF. DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Special cases:
  - DIV 5/0 -> 0xFFFFFFFF.
  - REM 5/0 -> 5.
  - DIV 0x80000000/-1 -> 0x80000000.
  - REM 0x80000000/-1 -> 0.
  - Each completes at +1 with busy never set.
- Start DIV 1000/3, toggle valid and operands while busy, then assert rst_i at BUSY cycle 10 -> the toggled inputs are ignored; on reset all outputs are immediately 0 and ready is 1, with no done; the next ADD 2+2 returns 4 at +1.
- XLEN=64, MDU_EN=0: MUL 3×4 -> 0 at +1. SLL 1<<63 -> 0x8000000000000000.
